// File: rtl/clk_meter_pkg.sv
// Shared state encoding and default sizing for the clock period meter.
package clk_meter_pkg;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_MEAS = 1'b1
  } state_t;

  localparam int CNT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 33554432;
  localparam int MEAS_CNT_W  = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser with rising-edge detect; o_rise is combinational from the last two flops.
// SYNC_STAGES must be at least 2.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_sig_s,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sig_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_sig_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_sig_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sig_s = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_sig_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures sig_in period in clk cycles between synchronised rising edges; sticky timeout on a missing edge.
// Define CLK_PERIOD_METER_DUTY_EN to also measure high time per period (otherwise high_time is 0).
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sig_in,
  input  logic                  clr,
  output logic [CNT_W-1:0]      period,
  output logic                  period_valid,
  output logic [MEAS_CNT_W-1:0] meas_cnt,
  output logic [CNT_W-1:0]      high_time,
  output logic                  timeout
);

  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic w_sig_s;
  logic w_rise;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]        r_period, w_period_nxt;
  logic                    r_pv, w_pv_nxt;
  logic [MEAS_CNT_W-1:0]   r_meas_cnt, w_meas_nxt;
  logic                    r_timeout, w_timeout_nxt;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_sig   (sig_in),
    .o_sig_s (w_sig_s),
    .o_rise  (w_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_WAIT;
      r_cnt      <= '0;
      r_period   <= '0;
      r_pv       <= 1'b0;
      r_meas_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_period   <= w_period_nxt;
      r_pv       <= w_pv_nxt;
      r_meas_cnt <= w_meas_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // A rise on the timeout count still wins: the edge arrived exactly on the limit.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_period_nxt  = r_period;
    w_pv_nxt      = 1'b0;
    w_meas_nxt    = r_meas_cnt;
    w_timeout_nxt = r_timeout;
    if (clr) begin
      w_state_nxt   = S_WAIT;
      w_cnt_nxt     = '0;
      w_period_nxt  = '0;
      w_meas_nxt    = '0;
      w_timeout_nxt = 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          w_cnt_nxt = '0;
          if (w_rise) begin
            w_state_nxt = S_MEAS;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        S_MEAS: begin
          if (w_rise) begin
            w_period_nxt = r_cnt;
            w_pv_nxt     = 1'b1;
            w_meas_nxt   = r_meas_cnt + 16'd1;
            w_cnt_nxt    = CNT_ONE;
          end else if (r_cnt == TO_CNT) begin
            w_timeout_nxt = 1'b1;
            w_state_nxt   = S_WAIT;
            w_cnt_nxt     = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] r_hcnt, w_hcnt_nxt;
  logic [CNT_W-1:0] r_high_time, w_high_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt      <= '0;
      r_high_time <= '0;
    end else begin
      r_hcnt      <= w_hcnt_nxt;
      r_high_time <= w_high_nxt;
    end
  end

  // The rise cycle itself is high, so a new period starts its high count at 1.
  always_comb begin
    w_hcnt_nxt = r_hcnt;
    w_high_nxt = r_high_time;
    if (clr) begin
      w_hcnt_nxt = '0;
      w_high_nxt = '0;
    end else if (r_state == S_WAIT) begin
      w_hcnt_nxt = w_rise ? CNT_ONE : '0;
    end else if (w_rise) begin
      w_high_nxt = r_hcnt;
      w_hcnt_nxt = CNT_ONE;
    end else if (r_cnt == TO_CNT) begin
      w_hcnt_nxt = '0;
    end else if (w_sig_s) begin
      w_hcnt_nxt = r_hcnt + CNT_ONE;
    end
  end

  assign high_time = r_high_time;
`else
  logic w_unused_sig_s;
  assign w_unused_sig_s = w_sig_s;
  assign high_time      = '0;
`endif

  assign period       = r_period;
  assign period_valid = r_pv;
  assign meas_cnt     = r_meas_cnt;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomised bench for clk_period_meter against a timestamp-based reference model.
module tb_clk_period_meter;

  localparam int CNT_W = 32;
  localparam int TO    = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic             clr;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [15:0]      meas_cnt;
  logic [CNT_W-1:0] high_time;
  logic             timeout;

  always #5 clk = ~clk;

  clk_period_meter #(
    .CNT_W          (CNT_W),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sig_in       (sig_in),
    .clr          (clr),
    .period       (period),
    .period_valid (period_valid),
    .meas_cnt     (meas_cnt),
    .high_time    (high_time),
    .timeout      (timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: samples of sig_in by edge, last detected rise time, published values.
  bit          h0, h1, h2, h3;
  bit          m_armed;
  int          m_last;
  logic [31:0] m_period;
  logic [15:0] m_meas;
  bit          m_to;
  bit          m_pv;
  logic [31:0] m_high;
  logic [31:0] m_hsum;
  int          n_pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    h0 = 0; h1 = 0; h2 = 0; h3 = 0;
    m_armed = 0; m_last = 0; m_period = 0; m_meas = 0;
    m_to = 0; m_pv = 0; m_high = 0; m_hsum = 0;
  endtask

  // An input rise sampled at edge k is acted on at edge k+2 (two synchroniser flops).
  task automatic model_edge(input bit s, input bit c);
    bit d, dp, rise;
    h3 = h2; h2 = h1; h1 = h0; h0 = s;
    d    = h2;
    dp   = h3;
    rise = d && !dp;
    m_pv = 0;
    if (c) begin
      m_armed = 0; m_period = 0; m_meas = 0; m_to = 0; m_high = 0; m_hsum = 0;
    end else if (rise) begin
      if (m_armed) begin
        m_period = 32'(cyc - m_last);
        m_pv     = 1;
        m_meas   = m_meas + 16'd1;
        m_high   = m_hsum;
      end
      m_armed = 1;
      m_last  = cyc;
      m_hsum  = 1;
    end else if (m_armed && (cyc - m_last) == TO) begin
      m_to    = 1;
      m_armed = 0;
    end else if (m_armed) begin
      m_hsum = m_hsum + 32'(d);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_high;
`ifdef CLK_PERIOD_METER_DUTY_EN
    exp_high = m_high;
`else
    exp_high = 32'd0;
`endif
    chk("period_valid", 32'(period_valid), 32'(m_pv));
    chk("period", period, m_period);
    chk("meas_cnt", 32'(meas_cnt), 32'(m_meas));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("high_time", high_time, exp_high);
    if (period_valid) n_pulses++;
  endtask

  task automatic step(input bit s, input bit c);
    sig_in = s;
    clr    = c;
    @(posedge clk);
    cyc++;
    model_edge(s, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    clr    = 1'b0;
    n_pulses = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Divide-by-4 waveform, then period 10 with 3-cycle high phase.
    wave(2, 2, 10);
    chk("pulses_div4", 32'(n_pulses), 32'd9);
    wave(3, 7, 6);

    // Missing edge -> sticky timeout; resumed wave does not clear it.
    hold_low(TO + 20);
    wave(4, 4, 5);
    step(1'b0, 1'b1);

    // Rise exactly on the limit, and one cycle past it.
    wave(10, TO - 10, 3);
    wave(10, TO - 9, 2);
    step(1'b0, 1'b1);

    // Clear on the same cycle the rise is acted on, then 6-cycle edges.
    hold_low(4);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    wave(3, 3, 2);
    chk("meas_after_clr", 32'(meas_cnt), 32'd1);

    // Randomised segments with occasional long gaps and clears.
    for (int k = 0; k < 250; k++) begin
      int hi, lo;
      hi = $urandom_range(1, 8);
      lo = ($urandom_range(0, 15) == 0) ? $urandom_range(50, 80) : $urandom_range(1, 8);
      for (int i = 0; i < hi; i++) step(1'b1, ($urandom_range(0, 99) == 0));
      for (int i = 0; i < lo; i++) step(1'b0, ($urandom_range(0, 99) == 0));
    end

    // Asynchronous reset mid-measurement.
    step(1'b0, 1'b1);
    wave(2, 2, 1);
    hold_low(28);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_period", period, m_period);
    chk("rst_meas", 32'(meas_cnt), 32'(m_meas));
    chk("rst_pv", 32'(period_valid), 32'(m_pv));
    chk("rst_timeout", 32'(timeout), 32'(m_to));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wave(5, 2, 1);
    chk("no_pv_first_edge", 32'(n_pulses), 32'(n_pulses));
    wave(5, 2, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
